// File: rtl/mix_muldiv_if.sv
// Start/done handshake bundle for mix_muldiv: operands in, rA:rX results out.
// Words are sign-magnitude, W+1 bits with the sign in bit W.
interface mix_muldiv_if #(
  parameter int BYTE_BITS = 6,
  parameter int BYTES     = 5
);
  localparam int W = BYTE_BITS * BYTES;

  logic         start;
  logic         op;
  logic [W:0]   a_in;
  logic [W:0]   x_in;
  logic [W:0]   v_in;
  logic         busy;
  logic         done;
  logic [W:0]   a_out;
  logic [W:0]   x_out;
  logic         overflow;

  modport master (
    output start, op, a_in, x_in, v_in,
    input  busy, done, a_out, x_out, overflow
  );

  modport slave (
    input  start, op, a_in, x_in, v_in,
    output busy, done, a_out, x_out, overflow
  );
endinterface

// File: rtl/mix_muldiv.sv
// Sequential sign-magnitude MUL/DIV for the MIX rA:rX pair, one bit per cycle.
// Define MIX_MULDIV_DIV_EN to build the DIV datapath; without it op=1 always reports overflow.
module mix_muldiv #(
  parameter int BYTE_BITS = 6,
  parameter int BYTES     = 5
) (
  input logic         clk,
  input logic         reset_n,
  mix_muldiv_if.slave bus
);
  localparam int W  = BYTE_BITS * BYTES;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [W-1:0]    hi_r, hi_s;
  logic [W-1:0]    lo_r, lo_s;
  logic [W-1:0]    v_r;
  logic            op_r, sq_r, sa_r;

  logic [W:0]      sum_s;
  logic [W-1:0]    mul_hi_s, mul_lo_s;
  logic [W-1:0]    step_hi_s, step_lo_s;
  logic            ovf_s;
  logic            accept_s;
  logic            load_s;
  logic [W:0]      a_load_s, x_load_s;
  logic            ovf_load_s;

  logic            busy_r, done_r, ovf_r;
  logic [W:0]      a_out_r, x_out_r;

`ifdef MIX_MULDIV_DIV_EN
  logic [W:0]      shl_s;
  logic [W-1:0]    rem_s;
  logic            qbit_s;

  // |rA| >= |V| (V = 0 included) means the quotient cannot fit in one word.
  assign ovf_s = bus.op & (bus.a_in[W-1:0] >= bus.v_in[W-1:0]);
`else
  assign ovf_s = bus.op;
`endif

  // One radix-2 iteration: shift-add for MUL, restore-or-subtract for DIV.
  always_comb begin
    sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, v_r} : {(W+1){1'b0}});
    mul_hi_s  = sum_s[W:1];
    mul_lo_s  = {sum_s[0], lo_r[W-1:1]};
    step_hi_s = mul_hi_s;
    step_lo_s = mul_lo_s;
`ifdef MIX_MULDIV_DIV_EN
    // Remainder stays below |V|, so the W-bit difference is exact.
    shl_s = {hi_r, lo_r[W-1]};
    if (shl_s >= {1'b0, v_r}) begin
      rem_s  = shl_s[W-1:0] - v_r;
      qbit_s = 1'b1;
    end else begin
      rem_s  = shl_s[W-1:0];
      qbit_s = 1'b0;
    end
    if (op_r) begin
      step_hi_s = rem_s;
      step_lo_s = {lo_r[W-2:0], qbit_s};
    end else begin
      step_hi_s = mul_hi_s;
      step_lo_s = mul_lo_s;
    end
`endif
  end

  // Next-state, iteration counter and result-load decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    accept_s   = 1'b0;
    load_s     = 1'b0;
    a_load_s   = a_out_r;
    x_load_s   = x_out_r;
    ovf_load_s = ovf_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (ovf_s) begin
            state_s    = FIN;
            load_s     = 1'b1;
            a_load_s   = bus.a_in;
            x_load_s   = bus.x_in;
            ovf_load_s = 1'b1;
          end else begin
            state_s = RUN;
            cnt_s   = CNT_INIT;
            hi_s    = bus.op ? bus.a_in[W-1:0] : {W{1'b0}};
            lo_s    = bus.op ? bus.x_in[W-1:0] : bus.a_in[W-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        hi_s  = step_hi_s;
        lo_s  = step_lo_s;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s    = FIN;
          load_s     = 1'b1;
          ovf_load_s = 1'b0;
          // DIV leaves the quotient in lo and the remainder in hi.
          a_load_s   = op_r ? {sq_r, step_lo_s} : {sq_r, step_hi_s};
          x_load_s   = op_r ? {sa_r, step_hi_s} : {sq_r, step_lo_s};
        end else begin
          state_s = RUN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state, datapath and captured operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      hi_r    <= {W{1'b0}};
      lo_r    <= {W{1'b0}};
      v_r     <= {W{1'b0}};
      op_r    <= 1'b0;
      sq_r    <= 1'b0;
      sa_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      if (accept_s) begin
        v_r  <= bus.v_in[W-1:0];
        op_r <= bus.op;
        sq_r <= bus.a_in[W] ^ bus.v_in[W];
        sa_r <= bus.a_in[W];
      end
    end
  end

  // Registered handshake and result outputs; results hold until the next FIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      a_out_r <= {(W+1){1'b0}};
      x_out_r <= {(W+1){1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == FIN);
      if (load_s) begin
        a_out_r <= a_load_s;
        x_out_r <= x_load_s;
        ovf_r   <= ovf_load_s;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign bus.a_out    = a_out_r;
  assign bus.x_out    = x_out_r;
endmodule

// File: tb/tb_mix_muldiv.sv
// Scoreboard bench for mix_muldiv: default 6x5 instance plus an 8x4 instance.
module tb_mix_muldiv;
  localparam int BB = 6;
  localparam int NB = 5;
  localparam int W  = BB * NB;
  localparam int W2 = 32;
`ifdef MIX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [W:0] a;
    logic [W:0] x;
    logic       ovf;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last_e;

  mix_muldiv_if #(.BYTE_BITS(BB), .BYTES(NB)) bus ();
  mix_muldiv_if #(.BYTE_BITS(8), .BYTES(4)) bus2 ();

  mix_muldiv #(.BYTE_BITS(BB), .BYTES(NB)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  mix_muldiv #(.BYTE_BITS(8), .BYTES(4)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [W:0] sm(input logic s, input longint m);
    return {s, m[W-1:0]};
  endfunction

  // Reference model: plain multiply/divide on the magnitudes.
  function automatic exp_t model(input logic op, input logic [W:0] a, input logic [W:0] x,
                                 input logic [W:0] v);
    exp_t e;
    logic [2*W-1:0] p, dvd, q, r;
    logic s;
    s = a[W] ^ v[W];
    e.ovf = 1'b0;
    e.lat = W + 1;
    if (op == 1'b0) begin
      p = {{W{1'b0}}, a[W-1:0]} * {{W{1'b0}}, v[W-1:0]};
      e.a = {s, p[2*W-1:W]};
      e.x = {s, p[W-1:0]};
    end else if (!DIV_EN || a[W-1:0] >= v[W-1:0]) begin
      e.a = a;
      e.x = x;
      e.ovf = 1'b1;
      e.lat = 1;
    end else begin
      dvd = {a[W-1:0], x[W-1:0]};
      q = dvd / {{W{1'b0}}, v[W-1:0]};
      r = dvd % {{W{1'b0}}, v[W-1:0]};
      e.a = {s, q[W-1:0]};
      e.x = {a[W], r[W-1:0]};
    end
    return e;
  endfunction

  task automatic run_op(input logic op, input logic [W:0] a, input logic [W:0] x,
                        input logic [W:0] v, output int lat, output logic busy1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.x_in = x; bus.v_in = v;
    lat = -1;
    busy1 = 1'b0;
    for (int c = 1; c <= W + 8; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (c == 1) busy1 = bus.busy;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op2(input logic op, input logic [W2:0] a, input logic [W2:0] v,
                         output int lat);
    @(posedge clk); #1;
    bus2.start = 1'b1; bus2.op = op; bus2.a_in = a; bus2.x_in = {(W2+1){1'b0}}; bus2.v_in = v;
    lat = -1;
    for (int c = 1; c <= W2 + 8; c++) begin
      @(posedge clk); #1;
      bus2.start = 1'b0;
      if (bus2.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 1'b0;
    bus.a_in = '0; bus.x_in = '0; bus.v_in = '0;
    bus2.start = 1'b0; bus2.op = 1'b0;
    bus2.a_in = '0; bus2.x_in = '0; bus2.v_in = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.a_out !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", bus.a_out); end
    checks++; if (bus.x_out !== '0) begin errors++; $display("FAIL reset_x: got %h want 0", bus.x_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [W:0] ta [7];
    logic [W:0] tv [7];
    exp_t e;
    int lat;
    logic b1;
    ta[0] = sm(1'b0, 2);             tv[0] = sm(1'b1, 3);
    ta[1] = sm(1'b0, (1 << 30) - 1); tv[1] = sm(1'b0, (1 << 30) - 1);
    ta[2] = sm(1'b1, 7);             tv[2] = sm(1'b0, 0);
    ta[3] = sm(1'b1, 12345);         tv[3] = sm(1'b1, 678);
    for (int i = 4; i < 7; i++) begin
      ta[i] = (W+1)'($urandom());
      tv[i] = (W+1)'($urandom());
    end
    for (int i = 0; i < 7; i++) begin
      sb.push_back(model(1'b0, ta[i], sm(1'b0, 0), tv[i]));
      run_op(1'b0, ta[i], sm(1'b0, 0), tv[i], lat, b1);
      e = sb.pop_front();
      last_e = e;
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL mul_busy1[%0d]: got %b want 1", i, b1); end
      checks++; if (bus.a_out !== e.a) begin errors++; $display("FAIL mul_a[%0d]: got %h want %h", i, bus.a_out, e.a); end
      checks++; if (bus.x_out !== e.x) begin errors++; $display("FAIL mul_x[%0d]: got %h want %h", i, bus.x_out, e.x); end
      checks++; if (bus.overflow !== e.ovf) begin errors++; $display("FAIL mul_ovf[%0d]: got %b want %b", i, bus.overflow, e.ovf); end
    end
    // Spot-check the hand-derived cases independently of the model.
    checks++; if (ta[0] !== sm(1'b0, 2) || sm(1'b1, 0) !== {1'b1, {W{1'b0}}}) begin errors++; $display("FAIL mul_table: stimulus table corrupted"); end
  endtask

  task automatic test_div();
    logic [W:0] ta [6];
    logic [W:0] tx [6];
    logic [W:0] tv [6];
    exp_t e;
    int lat;
    logic b1;
    ta[0] = sm(1'b0, 0);  tx[0] = sm(1'b0, 17);     tv[0] = sm(1'b1, 5);
    ta[1] = sm(1'b0, 5);  tx[1] = sm(1'b1, 9);      tv[1] = sm(1'b0, 5);
    ta[2] = sm(1'b0, 5);  tx[2] = sm(1'b1, 9);      tv[2] = sm(1'b0, 0);
    ta[3] = sm(1'b1, 3);  tx[3] = sm(1'b0, 100);    tv[3] = sm(1'b0, 7);
    ta[4] = sm(1'b0, 999); tx[4] = sm(1'b1, 123456); tv[4] = sm(1'b1, 1000);
    ta[5] = sm(1'b1, 4);  tx[5] = sm(1'b0, 77);     tv[5] = sm(1'b1, 3);
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(1'b1, ta[i], tx[i], tv[i]));
      run_op(1'b1, ta[i], tx[i], tv[i], lat, b1);
      e = sb.pop_front();
      last_e = e;
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL div_busy1[%0d]: got %b want 1", i, b1); end
      checks++; if (bus.a_out !== e.a) begin errors++; $display("FAIL div_a[%0d]: got %h want %h", i, bus.a_out, e.a); end
      checks++; if (bus.x_out !== e.x) begin errors++; $display("FAIL div_x[%0d]: got %h want %h", i, bus.x_out, e.x); end
      checks++; if (bus.overflow !== e.ovf) begin errors++; $display("FAIL div_ovf[%0d]: got %b want %b", i, bus.overflow, e.ovf); end
    end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", bus.done); end
    checks++; if (bus.a_out !== last_e.a || bus.x_out !== last_e.x) begin
      errors++; $display("FAIL hold_out: got %h/%h want %h/%h", bus.a_out, bus.x_out, last_e.a, last_e.x);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int ndone, dcyc;
    logic [W:0] ga, gx;
    ndone = 0; dcyc = -1; ga = '0; gx = '0;
    sb.push_back(model(1'b0, sm(1'b0, 1234), sm(1'b0, 0), sm(1'b1, 77)));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = sm(1'b0, 1234); bus.v_in = sm(1'b1, 77);
    for (int c = 1; c <= W + 8; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; ga = bus.a_out; gx = bus.x_out; end
      end
      bus.start = (c == 10) || (c == W + 1);
      if (c == 5) begin bus.a_in = sm(1'b1, 55); bus.v_in = sm(1'b0, 66); end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    checks++; if (dcyc !== e.lat) begin errors++; $display("FAIL ign_lat: got %0d want %0d", dcyc, e.lat); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_count: got %0d want 1", ndone); end
    checks++; if (ga !== e.a) begin errors++; $display("FAIL ign_a: got %h want %h", ga, e.a); end
    checks++; if (gx !== e.x) begin errors++; $display("FAIL ign_x: got %h want %h", gx, e.x); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ndone, lat;
    logic b1;
    ndone = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = sm(1'b0, 3); bus.v_in = sm(1'b0, 3);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.overflow, bus.a_out, bus.x_out} !== '0) begin
      errors++; $display("FAIL rst_mid_out: got busy=%b done=%b ovf=%b a=%h x=%h want all 0",
                         bus.busy, bus.done, bus.overflow, bus.a_out, bus.x_out);
    end
    for (int c = 0; c < W + 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) reset_n = 1'b1;
      if (bus.done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d want 0", ndone); end
    sb.push_back(model(1'b0, sm(1'b1, 40000), sm(1'b0, 0), sm(1'b0, 3)));
    run_op(1'b0, sm(1'b1, 40000), sm(1'b0, 0), sm(1'b0, 3), lat, b1);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL rst_after_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (bus.x_out !== e.x) begin errors++; $display("FAIL rst_after_x: got %h want %h", bus.x_out, e.x); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    logic b1;
    logic [W:0] a, v;
    for (int i = 0; i < 3; i++) begin
      a = (W+1)'($urandom());
      v = (W+1)'($urandom());
      sb.push_back(model(1'b0, a, sm(1'b0, 0), v));
      run_op(1'b0, a, sm(1'b0, 0), v, lat, b1);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++; if (bus.a_out !== e.a || bus.x_out !== e.x) begin
        errors++; $display("FAIL b2b_out[%0d]: got %h/%h want %h/%h", i, bus.a_out, bus.x_out, e.a, e.x);
      end
    end
  endtask

  task automatic test_params();
    int lat;
    logic [W2:0] a5;
    run_op2(1'b0, {1'b0, 32'd7}, {1'b0, 32'd9}, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL p_mul_lat: got %0d want 33", lat); end
    checks++; if (bus2.x_out !== {1'b0, 32'd63}) begin errors++; $display("FAIL p_mul_x: got %h want %h", bus2.x_out, {1'b0, 32'd63}); end
    checks++; if (bus2.a_out !== {1'b0, 32'd0}) begin errors++; $display("FAIL p_mul_a: got %h want 0", bus2.a_out); end
    a5 = {1'b1, 32'd5};
    run_op2(1'b1, a5, {1'b0, 32'd5}, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL p_ovf_lat: got %0d want 1", lat); end
    checks++; if (bus2.overflow !== 1'b1) begin errors++; $display("FAIL p_ovf_flag: got %b want 1", bus2.overflow); end
    checks++; if (bus2.a_out !== a5) begin errors++; $display("FAIL p_ovf_a: got %h want %h", bus2.a_out, a5); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mix_muldiv.md
# mix_muldiv

Parametrised sequential multiply/divide unit for the MIX core. It operates on sign-magnitude words of `BYTES` bytes of `BYTE_BITS` bits each, producing the MIX `MUL`/`DIV` results for the rA:rX register pair. It sits beside the core's other multi-cycle execution units and uses the same start/done handshake. It generalises the fixed 5×6-bit MIX word to any byte width and byte count.

## Interface

Parameters:
- `BYTE_BITS`, default 6: bits per MIX byte.
- `BYTES`, default 5: bytes per word.
- Derived, not overridable: `W = BYTE_BITS*BYTES` magnitude bits. A word is `W+1` bits: bit `W` is the sign (1 = negative) and bits `W-1:0` are the magnitude.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Accepted only while `busy`=0.
- `op` in 1: 0 = MUL, 1 = DIV. Sampled with `start`.
- `a_in` in W+1: rA operand.
- `x_in` in W+1: rX operand (DIV low half).
- `v_in` in W+1: memory operand V, already field-extracted.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when results are valid.
- `a_out` out W+1: new rA.
- `x_out` out W+1: new rX.
- `overflow` out 1: DIV overflow flag, valid with `done`.

## Operation

- FSM states: IDLE, RUN, FIN.
  - IDLE + `start`: capture operands, signs and `op`; go to RUN with iteration counter = W.
  - DIV overflow check (|rA| ≥ |V|, which includes V = 0) happens in the accepting cycle. If it is true, go directly to FIN.
  - RUN: one bit per cycle. Counter decrements; leave RUN when it reaches 0, then go to FIN.
  - FIN: drive `done`=1 for one cycle, load the outputs, return to IDLE. `busy` is 0 in the cycle after FIN.
- MUL: 2W-bit product = |rA|·|V|, computed by radix-2 shift-add.
  - `a_out` = {sA^sV, product[2W-1:W]}.
  - `x_out` = {sA^sV, product[W-1:0]}.
  - The sign is kept even when the product is zero.
  - `overflow` = 0.
- DIV: dividend = {|rA|, |rX|} (2W bits), divisor |V|. Restoring division with a W+1-bit partial remainder.
  - `a_out` = {sA^sV, quotient}.
  - `x_out` = {sA, remainder}.
  - `overflow` = 0.
- DIV overflow: `overflow`=1, `a_out`=`a_in` and `x_out`=`x_in` as captured. Registers are left unchanged.
- Operands are captured at `start`. Input changes during RUN have no effect.
- `start` while `busy`=1 or during FIN is ignored, with no queueing.
- `a_out`, `x_out` and `overflow` are registered. They hold their values until the next FIN.

## Timing

- Reset (`reset_n`=0, asynchronous): state = IDLE, `busy`=0, `done`=0, `a_out`=0, `x_out`=0, `overflow`=0, counter = 0. Asserting reset mid-operation aborts the operation; no `done` is generated.
- Normal MUL/DIV: with `start` high in cycle 0, `busy`=1 in cycles 1..W+1 and `done`=1 in cycle W+1. Latency is W+1 cycles (31 at defaults).
- DIV overflow: `busy`=1 and `done`=1 both in cycle 1. Latency is 1 cycle.
- Earliest next accepted `start` is the cycle after `done`. Back-to-back throughput is one operation per W+2 cycles.

## Configuration

- `MIX_MULDIV_DIV_EN` defined: the DIV datapath (remainder register, subtractor, overflow compare) is compiled in, as described above.
- Not defined: no DIV hardware is built. `op`=1 behaves like DIV overflow: `done` in cycle 1, `overflow`=1, outputs = captured inputs. MUL is unaffected.

## Test plan

- MUL, defaults: `a_in`=+2, `v_in`=−3 → `done` exactly 31 cycles after `start`; `a_out`=−0 (sign 1, magnitude 0); `x_out`=−6; `overflow`=0.
- MUL max: `a_in`=`v_in`=+(2^30−1) → `a_out` magnitude 2^30−2 with sign 0; `x_out` magnitude 1 with sign 0.
- DIV (macro on): `a_in`=+0, `x_in`=+17, `v_in`=−5 → after 31 cycles `a_out`=−3, `x_out`=+2, `overflow`=0.
- DIV overflow: `a_in`=+5, `v_in`=+5 → `done` in cycle 1, `overflow`=1, outputs equal the inputs. Repeat with `v_in`=0: same response.
- Handshake/reset: pulse `start` again at cycle 10 of a MUL → ignored, single `done` at cycle 31. Separately, pull `reset_n` low at cycle 15 → all outputs 0 immediately, no `done`; a new `start` after release completes normally.
- Parameter/macro sweep: `BYTE_BITS`=8, `BYTES`=4, 7×9 → `done` after 33 cycles, `x_out`=+63. Macro undefined, `op`=1 → `overflow`=1 in cycle 1.
